// File: rtl/johnson_code_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : johnson_code_tracker
//  Description : Receive-side monitor for a WIDTH-bit Johnson counter.
//                Decodes each sampled code to a position index, classifies
//                the transition (hold / up / down / jump / illegal), acquires
//                lock after LOCK_STEPS clean transitions and then keeps a
//                wrapping net-step position accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
module johnson_code_tracker #(
  parameter int WIDTH      = 4,
  parameter int IDX_W      = $clog2(2*WIDTH),
  parameter int CNT_W      = 16,
  parameter int LOCK_STEPS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_valid,
  input  logic             err_clr,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             step_up,
  output logic             step_down,
  output logic             hold,
  output logic             jump,
  output logic             illegal,
  output logic             locked,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pos
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_seq_len = 2 * WIDTH;
  localparam int c_mcnt_w  = $clog2(LOCK_STEPS + 1);

  localparam logic [IDX_W-1:0]    c_idx_last  = IDX_W'(c_seq_len - 1);
  localparam logic [IDX_W-1:0]    c_idx_one   = IDX_W'(1);
  localparam logic [c_mcnt_w-1:0] c_mcnt_one  = c_mcnt_w'(1);
  localparam logic [c_mcnt_w-1:0] c_mcnt_lock = c_mcnt_w'(LOCK_STEPS);
  localparam logic [CNT_W-1:0]    c_pos_one   = CNT_W'(1);

  // Tracker states; UNLOCKED and ERROR both lack a trusted previous index.
  localparam logic [1:0] c_st_unlocked = 2'd0;
  localparam logic [1:0] c_st_acquire  = 2'd1;
  localparam logic [1:0] c_st_locked   = 2'd2;
  localparam logic [1:0] c_st_error    = 2'd3;

  // --------------------------------------------------------------------------
  // Reference Johnson code for sequence position k.
  // Positions 0..WIDTH-1 fill ones in from the MSB (k+1 ones); positions
  // WIDTH..2*WIDTH-1 drain them out, leaving 2*WIDTH-1-k ones at the LSB end.
  // --------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] johnson_code(input int k);
    logic [WIDTH-1:0] code;
    code = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (k < WIDTH) begin
        code[b] = (b >= (WIDTH - 1 - k));
      end else begin
        code[b] = (b < (c_seq_len - 1 - k));
      end
    end
    return code;
  endfunction

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [1:0]          state_q,      state_d;
  logic [c_mcnt_w-1:0] mcnt_q,       mcnt_d;
  logic [IDX_W-1:0]    idx_q,        idx_d;
  logic                idx_valid_q,  idx_valid_d;
  logic                step_up_q,    step_up_d;
  logic                step_down_q,  step_down_d;
  logic                hold_q,       hold_d;
  logic                jump_q,       jump_d;
  logic                illegal_q,    illegal_d;
  logic                err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]    pos_q,        pos_d;

  // --------------------------------------------------------------------------
  // Combinational decode / classification wires
  // --------------------------------------------------------------------------
  logic                w_dec_legal;
  logic [IDX_W-1:0]    w_dec_idx;
  logic [IDX_W-1:0]    w_prev_inc;
  logic [IDX_W-1:0]    w_prev_dec;
  logic                w_is_hold;
  logic                w_is_up;
  logic                w_is_down;
  logic                w_is_jump;
  logic                w_is_clean;
  logic [c_mcnt_w-1:0] w_mcnt_inc;

  // Match code_in against every legal Johnson code; no match means illegal.
  always_comb begin
    w_dec_legal = 1'b0;
    w_dec_idx   = '0;
    for (int k = 0; k < c_seq_len; k++) begin
      if (code_in == johnson_code(k)) begin
        w_dec_legal = 1'b1;
        w_dec_idx   = IDX_W'(k);
      end
    end
  end

  // Neighbours of the stored index, wrapping around the 2*WIDTH ring.
  always_comb begin
    w_prev_inc = (idx_q == c_idx_last) ? '0 : (idx_q + c_idx_one);
    w_prev_dec = (idx_q == '0) ? c_idx_last : (idx_q - c_idx_one);
  end

  // Classify a legal decode relative to the stored previous index.
  always_comb begin
    w_is_hold  = w_dec_legal && (w_dec_idx == idx_q);
    w_is_up    = w_dec_legal && (w_dec_idx == w_prev_inc);
    w_is_down  = w_dec_legal && (w_dec_idx == w_prev_dec);
    w_is_jump  = w_dec_legal && !(w_is_hold || w_is_up || w_is_down);
    w_is_clean = w_is_hold || w_is_up || w_is_down;
    w_mcnt_inc = mcnt_q + c_mcnt_one;
  end

  // Next-state logic for the tracker FSM, pulses, index and accumulator.
  always_comb begin
    state_d      = state_q;
    mcnt_d       = mcnt_q;
    idx_d        = idx_q;
    idx_valid_d  = idx_valid_q;
    pos_d        = pos_q;
    step_up_d    = 1'b0;
    step_down_d  = 1'b0;
    hold_d       = 1'b0;
    jump_d       = 1'b0;
    illegal_d    = 1'b0;
    // A set condition below overrides this clear within the same cycle.
    err_sticky_d = err_sticky_q & ~err_clr;

    if (code_valid) begin
      case (state_q)
        // No previous index: any legal code becomes the acquisition seed.
        c_st_unlocked, c_st_error: begin
          if (w_dec_legal) begin
            idx_d       = w_dec_idx;
            idx_valid_d = 1'b1;
            mcnt_d      = '0;
            state_d     = c_st_acquire;
          end else begin
            illegal_d   = 1'b1;
          end
        end

        // Count clean transitions; a jump restarts the run from the new index.
        c_st_acquire: begin
          if (!w_dec_legal) begin
            illegal_d   = 1'b1;
            idx_valid_d = 1'b0;
            mcnt_d      = '0;
            state_d     = c_st_unlocked;
          end else if (w_is_clean) begin
            hold_d = w_is_hold;
            idx_d  = w_dec_idx;
            if (w_mcnt_inc >= c_mcnt_lock) begin
              mcnt_d  = '0;
              pos_d   = '0;
              state_d = c_st_locked;
            end else begin
              mcnt_d  = w_mcnt_inc;
            end
          end else begin
            jump_d = 1'b1;
            idx_d  = w_dec_idx;
            mcnt_d = '0;
          end
        end

        // Track single steps; any discontinuity drops to ERROR and latches err.
        c_st_locked: begin
          if (!w_dec_legal) begin
            illegal_d    = 1'b1;
            err_sticky_d = 1'b1;
            idx_valid_d  = 1'b0;
            state_d      = c_st_error;
          end else if (w_is_jump) begin
            jump_d       = 1'b1;
            err_sticky_d = 1'b1;
            idx_d        = w_dec_idx;
            state_d      = c_st_error;
          end else if (w_is_up) begin
            step_up_d    = 1'b1;
            idx_d        = w_dec_idx;
            pos_d        = pos_q + c_pos_one;
          end else if (w_is_down) begin
            step_down_d  = 1'b1;
            idx_d        = w_dec_idx;
            pos_d        = pos_q - c_pos_one;
          end else begin
            hold_d       = 1'b1;
          end
        end

        default: begin
          state_d = c_st_unlocked;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= c_st_unlocked;
      mcnt_q       <= '0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      step_up_q    <= 1'b0;
      step_down_q  <= 1'b0;
      hold_q       <= 1'b0;
      jump_q       <= 1'b0;
      illegal_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      pos_q        <= '0;
    end else begin
      state_q      <= state_d;
      mcnt_q       <= mcnt_d;
      idx_q        <= idx_d;
      idx_valid_q  <= idx_valid_d;
      step_up_q    <= step_up_d;
      step_down_q  <= step_down_d;
      hold_q       <= hold_d;
      jump_q       <= jump_d;
      illegal_q    <= illegal_d;
      err_sticky_q <= err_sticky_d;
      pos_q        <= pos_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign idx        = idx_q;
  assign idx_valid  = idx_valid_q;
  assign step_up    = step_up_q;
  assign step_down  = step_down_q;
  assign hold       = hold_q;
  assign jump       = jump_q;
  assign illegal    = illegal_q;
  assign locked     = (state_q == c_st_locked);
  assign err_sticky = err_sticky_q;
  assign pos        = pos_q;

endmodule
`default_nettype wire

// File: tb/tb_johnson_code_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_johnson_code_tracker
//  Description : Directed, table-driven self-checking bench for
//                johnson_code_tracker (WIDTH=4, LOCK_STEPS=3, CNT_W=16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_johnson_code_tracker;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic        clk;
  logic        rst;
  logic [3:0]  code_in;
  logic        code_valid;
  logic        err_clr;
  logic [2:0]  idx;
  logic        idx_valid, step_up, step_down, hold, jump, illegal, locked, err_sticky;
  logic [15:0] pos;

  int n_pass;
  int n_total;

  typedef struct {
    logic        v;
    logic [3:0]  code;
    logic        clr;
    logic [2:0]  idx;
    logic        iv, up, dn, hd, jp, il, lk, er;
    logic [15:0] pos;
  } vec_t;

  vec_t tbl[32];

  johnson_code_tracker #(
    .WIDTH(4), .IDX_W(3), .CNT_W(16), .LOCK_STEPS(3)
  ) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .err_clr(err_clr), .idx(idx), .idx_valid(idx_valid), .step_up(step_up),
    .step_down(step_down), .hold(hold), .jump(jump), .illegal(illegal),
    .locked(locked), .err_sticky(err_sticky), .pos(pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare all outputs against one expected record.
  task automatic check(input string name, input vec_t e);
    logic [26:0] act, exp;
    act = {idx, idx_valid, step_up, step_down, hold, jump, illegal, locked, err_sticky, pos};
    exp = {e.idx, e.iv, e.up, e.dn, e.hd, e.jp, e.il, e.lk, e.er, e.pos};
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got idx=%0d iv=%b up=%b dn=%b hold=%b jump=%b ill=%b lk=%b err=%b pos=%h, want idx=%0d iv=%b up=%b dn=%b hold=%b jump=%b ill=%b lk=%b err=%b pos=%h",
               name, idx, idx_valid, step_up, step_down, hold, jump, illegal, locked, err_sticky, pos,
               e.idx, e.iv, e.up, e.dn, e.hd, e.jp, e.il, e.lk, e.er, e.pos);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check just after rising edge.
  task automatic apply(input string name, input vec_t e);
    @(negedge clk);
    code_valid = e.v;
    code_in    = e.code;
    err_clr    = e.clr;
    @(posedge clk);
    #1;
    check(name, e);
  endtask

  initial begin
    vec_t r;
    vec_t zero;
    n_pass = 0; n_total = 0;
    rst = 1'b1; code_valid = 1'b0; code_in = 4'b0000; err_clr = 1'b0;
    zero = '{N, 4'b0000, N, 3'd0, N, N, N, N, N, N, N, N, 16'h0000};

    //            v  code     clr  idx   iv up dn hd jp il lk er pos
    // Acquire and lock on an up run, then one locked up step.
    tbl[0]  = '{Y, 4'b1000, N, 3'd0, Y, N, N, N, N, N, N, N, 16'h0000};
    tbl[1]  = '{Y, 4'b1100, N, 3'd1, Y, N, N, N, N, N, N, N, 16'h0000};
    tbl[2]  = '{Y, 4'b1110, N, 3'd2, Y, N, N, N, N, N, N, N, 16'h0000};
    tbl[3]  = '{Y, 4'b1111, N, 3'd3, Y, N, N, N, N, N, Y, N, 16'h0000};
    tbl[4]  = '{Y, 4'b0111, N, 3'd4, Y, Y, N, N, N, N, Y, N, 16'h0001};
    // Illegal while locked, then reacquire; idle sample of an illegal code.
    tbl[5]  = '{Y, 4'b1010, N, 3'd4, N, N, N, N, N, Y, N, Y, 16'h0001};
    tbl[6]  = '{Y, 4'b0011, N, 3'd5, Y, N, N, N, N, N, N, Y, 16'h0001};
    tbl[7]  = '{N, 4'b1010, N, 3'd5, Y, N, N, N, N, N, N, Y, 16'h0001};
    tbl[8]  = '{Y, 4'b0001, N, 3'd6, Y, N, N, N, N, N, N, Y, 16'h0001};
    tbl[9]  = '{Y, 4'b0000, N, 3'd7, Y, N, N, N, N, N, N, Y, 16'h0001};
    // Lock completed by a hold transition: hold pulse, pos reset to 0.
    tbl[10] = '{Y, 4'b0000, N, 3'd7, Y, N, N, Y, N, N, Y, Y, 16'h0000};
    tbl[11] = '{Y, 4'b1000, N, 3'd0, Y, Y, N, N, N, N, Y, Y, 16'h0001};
    tbl[12] = '{Y, 4'b1100, N, 3'd1, Y, Y, N, N, N, N, Y, Y, 16'h0002};
    // Down steps across index wrap 0 -> 7 and pos wrap 0 -> FFFF.
    tbl[13] = '{Y, 4'b1000, N, 3'd0, Y, N, Y, N, N, N, Y, Y, 16'h0001};
    tbl[14] = '{Y, 4'b0000, N, 3'd7, Y, N, Y, N, N, N, Y, Y, 16'h0000};
    tbl[15] = '{Y, 4'b0001, N, 3'd6, Y, N, Y, N, N, N, Y, Y, 16'hFFFF};
    tbl[16] = '{Y, 4'b0001, N, 3'd6, Y, N, N, Y, N, N, Y, Y, 16'hFFFF};
    tbl[17] = '{Y, 4'b0011, N, 3'd5, Y, N, Y, N, N, N, Y, Y, 16'hFFFE};
    // err_clr alone, then idle.
    tbl[18] = '{N, 4'b0000, Y, 3'd5, Y, N, N, N, N, N, Y, N, 16'hFFFE};
    tbl[19] = '{N, 4'b0000, N, 3'd5, Y, N, N, N, N, N, Y, N, 16'hFFFE};
    // Jump while locked, then first sample in ERROR only seeds acquisition.
    tbl[20] = '{Y, 4'b1000, N, 3'd0, Y, N, N, N, Y, N, N, Y, 16'hFFFE};
    tbl[21] = '{Y, 4'b1100, N, 3'd1, Y, N, N, N, N, N, N, Y, 16'hFFFE};
    tbl[22] = '{Y, 4'b1110, N, 3'd2, Y, N, N, N, N, N, N, Y, 16'hFFFE};
    tbl[23] = '{Y, 4'b1111, N, 3'd3, Y, N, N, N, N, N, N, Y, 16'hFFFE};
    tbl[24] = '{Y, 4'b0111, N, 3'd4, Y, N, N, N, N, N, Y, Y, 16'h0000};
    // Clear alone, then clear colliding with a locked illegal: set wins.
    tbl[25] = '{N, 4'b0000, Y, 3'd4, Y, N, N, N, N, N, Y, N, 16'h0000};
    tbl[26] = '{Y, 4'b0101, Y, 3'd4, N, N, N, N, N, Y, N, Y, 16'h0000};
    tbl[27] = '{Y, 4'b0101, N, 3'd4, N, N, N, N, N, Y, N, Y, 16'h0000};
    // Clear in ERROR; ACQUIRE jump and illegal must not set err.
    tbl[28] = '{Y, 4'b1111, Y, 3'd3, Y, N, N, N, N, N, N, N, 16'h0000};
    tbl[29] = '{Y, 4'b1000, N, 3'd0, Y, N, N, N, Y, N, N, N, 16'h0000};
    tbl[30] = '{Y, 4'b0100, N, 3'd0, N, N, N, N, N, Y, N, N, 16'h0000};
    tbl[31] = '{Y, 4'b0100, N, 3'd0, N, N, N, N, N, Y, N, N, 16'h0000};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", zero);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // Relock from UNLOCKED (idx 0) and advance pos to 5.
    apply("relock0", '{Y, 4'b1000, N, 3'd0, Y, N, N, N, N, N, N, N, 16'h0000});
    apply("relock1", '{Y, 4'b1100, N, 3'd1, Y, N, N, N, N, N, N, N, 16'h0000});
    apply("relock2", '{Y, 4'b1110, N, 3'd2, Y, N, N, N, N, N, N, N, 16'h0000});
    apply("relock3", '{Y, 4'b1111, N, 3'd3, Y, N, N, N, N, N, Y, N, 16'h0000});
    apply("run_up1", '{Y, 4'b0111, N, 3'd4, Y, Y, N, N, N, N, Y, N, 16'h0001});
    apply("run_up2", '{Y, 4'b0011, N, 3'd5, Y, Y, N, N, N, N, Y, N, 16'h0002});
    apply("run_up3", '{Y, 4'b0001, N, 3'd6, Y, Y, N, N, N, N, Y, N, 16'h0003});
    apply("run_up4", '{Y, 4'b0000, N, 3'd7, Y, Y, N, N, N, N, Y, N, 16'h0004});
    apply("run_up5", '{Y, 4'b1000, N, 3'd0, Y, Y, N, N, N, N, Y, N, 16'h0005});

    // Ten idle cycles with a changing (even illegal) code: nothing moves.
    for (int i = 0; i < 10; i++) begin
      r = '{N, 4'(i * 5), N, 3'd0, Y, N, N, N, N, N, Y, N, 16'h0005};
      apply($sformatf("idle%0d", i), r);
    end

    // Asynchronous reset between edges while locked.
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", zero);
    #1;
    rst = 1'b0;
    apply("post_reset_idle", zero);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
